// File: rtl/axi4_mem_slave_if.sv
// AXI4 bus bundle (128-bit data, 30-bit address, 4-bit id) between the FIFO-to-AXI adapter and the memory model.
interface axi4_mem_slave_if;
  logic [3:0]   awid;
  logic [29:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;

  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;

  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  logic [3:0]   arid;
  logic [29:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;

  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_mem_slave.sv
// AXI4 memory responder: one write and one read burst in flight, byte-lane block RAM, emulated init_done.
// Optional random back-pressure is enabled with the macro AXI4_MEM_SLAVE_STALL_EN.
module axi4_mem_slave #(
  parameter int          MEM_AW      = 10,
  parameter int          INIT_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            init_done,
  axi4_mem_slave_if.slave s_axi
);
  localparam int DEPTH = 1 << MEM_AW;
  localparam int ICW   = $clog2(INIT_CYCLES + 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // ---------------- calibration-done emulation ----------------
  logic [ICW-1:0] r_init_cnt;
  logic           r_init_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else if (!r_init_done) begin
      if (r_init_cnt == ICW'(INIT_CYCLES - 1)) r_init_done <= 1'b1;
      else                                    r_init_cnt  <= r_init_cnt + 1'b1;
    end
  end

  assign init_done = r_init_done;

  // ---------------- optional stall source ----------------
  logic w_wstall;
  logic w_rhold;
  logic w_astall;

`ifdef AXI4_MEM_SLAVE_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_wstall = r_lfsr[0];
  assign w_rhold  = r_lfsr[1];
  assign w_astall = r_lfsr[2];
`else
  assign w_wstall = 1'b0;
  assign w_rhold  = 1'b0;
  assign w_astall = 1'b0;
`endif

  // ---------------- write FSM ----------------
  w_state_t          r_wstate, w_wstate_next;
  logic [MEM_AW-1:0] r_waddr;
  logic [3:0]        r_wid;
  logic [7:0]        r_wlen;
  logic [8:0]        r_wcnt;
  logic              r_werr;
  logic              w_awready, w_wready, w_bvalid;
  logic              w_aw_hs, w_w_hs, w_wbeat_ok, w_mem_we;

  always_ff @(posedge clk) begin
    if (!rst_n) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_next;
  end

  always_comb begin
    w_wstate_next = r_wstate;
    w_awready     = 1'b0;
    w_wready      = 1'b0;
    w_bvalid      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = r_init_done & ~w_astall;
        if (s_axi.awvalid && w_awready) w_wstate_next = W_DATA;
      end
      W_DATA: begin
        w_wready = ~w_wstall;
        if (s_axi.wvalid && w_wready && s_axi.wlast) w_wstate_next = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (s_axi.bready) w_wstate_next = W_IDLE;
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  assign w_aw_hs    = s_axi.awvalid & w_awready;
  assign w_w_hs     = s_axi.wvalid & w_wready;
  assign w_wbeat_ok = (r_wcnt <= {1'b0, r_wlen});
  // Gated by reset so a burst cut off by reset never touches memory.
  assign w_mem_we   = w_w_hs & w_wbeat_ok & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wid   <= '0;
      r_waddr <= '0;
      r_wlen  <= '0;
      r_wcnt  <= '0;
      r_werr  <= 1'b0;
    end else if (w_aw_hs) begin
      r_wid   <= s_axi.awid;
      r_waddr <= s_axi.awaddr[MEM_AW+3:4];
      r_wlen  <= s_axi.awlen;
      r_wcnt  <= '0;
      r_werr  <= (s_axi.awsize != 3'b100) || (s_axi.awburst != 2'b01);
    end else if (w_w_hs) begin
      r_waddr <= r_waddr + 1'b1;
      if (r_wcnt != 9'h1FF) r_wcnt <= r_wcnt + 1'b1;
      if (!w_wbeat_ok || (s_axi.wlast && (r_wcnt != {1'b0, r_wlen}))) r_werr <= 1'b1;
    end
  end

  assign s_axi.awready = w_awready;
  assign s_axi.wready  = w_wready;
  assign s_axi.bvalid  = w_bvalid;
  assign s_axi.bid     = r_wid;
  assign s_axi.bresp   = {r_werr, 1'b0};

  // ---------------- read FSM ----------------
  r_state_t          r_rstate, w_rstate_next;
  logic [MEM_AW-1:0] r_raddr;
  logic [3:0]        r_rid;
  logic [7:0]        r_rlen;
  logic [7:0]        r_rcnt;
  logic              r_rerr;
  logic              r_rshown;
  logic              w_arready, w_rvalid, w_rlast, w_r_hs, w_ar_hs;
  logic              w_rd_load;
  logic [MEM_AW-1:0] w_rd_idx;
  logic [127:0]      w_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_next;
  end

  assign w_rlast = (r_rstate == R_DATA) && (r_rcnt == r_rlen);

  always_comb begin
    w_rstate_next = r_rstate;
    w_arready     = 1'b0;
    w_rvalid      = 1'b0;
    w_rd_load     = 1'b0;
    w_rd_idx      = r_raddr + 1'b1;
    case (r_rstate)
      R_IDLE: begin
        w_arready = r_init_done & ~w_astall;
        w_rd_idx  = s_axi.araddr[MEM_AW+3:4];
        if (s_axi.arvalid && w_arready) begin
          w_rd_load     = 1'b1;
          w_rstate_next = R_DATA;
        end
      end
      R_DATA: begin
        // A beat already on the bus is never withdrawn.
        w_rvalid = r_rshown | ~w_rhold;
        if (w_rvalid && s_axi.rready) begin
          if (w_rlast) w_rstate_next = R_IDLE;
          else         w_rd_load     = 1'b1;
        end
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  assign w_ar_hs = s_axi.arvalid & w_arready;
  assign w_r_hs  = w_rvalid & s_axi.rready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rerr   <= 1'b0;
      r_rshown <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_rid   <= s_axi.arid;
        r_raddr <= s_axi.araddr[MEM_AW+3:4];
        r_rlen  <= s_axi.arlen;
        r_rcnt  <= '0;
        r_rerr  <= (s_axi.arsize != 3'b100) || (s_axi.arburst != 2'b01);
      end else if (w_r_hs && !w_rlast) begin
        r_raddr <= r_raddr + 1'b1;
        r_rcnt  <= r_rcnt + 1'b1;
      end
      if (w_r_hs || r_rstate != R_DATA) r_rshown <= 1'b0;
      else if (w_rvalid)                r_rshown <= 1'b1;
    end
  end

  // ---------------- byte-lane memory with registered read ----------------
  for (genvar gi = 0; gi < 16; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rbyte;

    always_ff @(posedge clk) begin
      if (w_mem_we && s_axi.wstrb[gi]) r_mem[r_waddr] <= s_axi.wdata[gi*8 +: 8];
    end

    // Non-blocking update gives read-before-write on a same-word collision.
    always_ff @(posedge clk) begin
      if (!rst_n)         r_rbyte <= '0;
      else if (w_rd_load) r_rbyte <= r_mem[w_rd_idx];
    end

    assign w_rdata[gi*8 +: 8] = r_rbyte;
  end

  assign s_axi.arready = w_arready;
  assign s_axi.rvalid  = w_rvalid;
  assign s_axi.rid     = r_rid;
  assign s_axi.rdata   = w_rdata;
  assign s_axi.rresp   = {r_rerr, 1'b0};
  assign s_axi.rlast   = w_rlast;
endmodule

// File: tb/tb_axi4_mem_slave.sv
// Scoreboard bench for axi4_mem_slave: expected B and R responses are queued at stimulus time and checked by monitors.
module tb_axi4_mem_slave;
  localparam int TMO = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;

  axi4_mem_slave_if bus();

  axi4_mem_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .s_axi     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] id;
    logic       err;
  } bexp_t;

  typedef struct packed {
    logic [3:0]   id;
    logic         err;
    logic         last;
    logic [127:0] data;
  } rexp_t;

  bexp_t        bq[$];
  rexp_t        rq[$];
  logic [127:0] mdl [1024];
  int           n_total = 0;
  int           n_bad   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  logic         r_hold = 1'b0;
  logic [127:0] hold_data;
  logic         hold_last;
  logic [3:0]   hold_id;

  always @(negedge clk) begin
    rexp_t re;
    bexp_t be;
    if (rst_n) begin
      if (r_hold) begin
        check("r_hold_data", bus.rdata, hold_data);
        check("r_hold_last", bus.rlast, hold_last);
        check("r_hold_id", bus.rid, hold_id);
      end
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) check("r_unexp", bus.rvalid, 1'b0);
        else begin
          re = rq.pop_front();
          check("r_data", bus.rdata, re.data);
          check("r_last", bus.rlast, re.last);
          check("r_id", bus.rid, re.id);
          check("r_resp", bus.rresp, {re.err, 1'b0});
        end
      end
      r_hold    = bus.rvalid && !bus.rready;
      hold_data = bus.rdata;
      hold_last = bus.rlast;
      hold_id   = bus.rid;
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) check("b_unexp", bus.bvalid, 1'b0);
        else begin
          be = bq.pop_front();
          check("b_id", bus.bid, be.id);
          check("b_resp", bus.bresp, {be.err, 1'b0});
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic axi_write(input logic [29:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int nbeats,
                           input int last_beat, input logic [127:0] d0, input bit incr,
                           input logic [15:0] strb);
    logic         err;
    logic [9:0]   idx;
    logic [127:0] d;
    int           n;
    err = (size != 3'b100) || (burst != 2'b01) || (last_beat != int'(len)) || (nbeats > int'(len) + 1);
    bq.push_back('{id: id, err: err});
    for (int b = 0; b < nbeats && b <= int'(len); b++) begin
      idx = addr[13:4] + 10'(b);
      d   = incr ? d0 + 128'(b) : d0;
      for (int k = 0; k < 16; k++)
        if (strb[k]) mdl[idx][k*8 +: 8] = d[k*8 +: 8];
    end
    $display("write addr=%0h len=%0d size=%0d burst=%0d id=%0d beats=%0d exp_err=%0d",
             addr, len, size, burst, id, nbeats, err);

    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.awready && n < TMO);
    check("aw_hs", bus.awready, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;

    for (int b = 0; b < nbeats; b++) begin
      bus.wdata  = incr ? d0 + 128'(b) : d0;
      bus.wstrb  = strb;
      bus.wlast  = (b == last_beat);
      bus.wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.wready && n < TMO);
      check("w_hs", bus.wready, 1'b1);
`ifndef AXI4_MEM_SLAVE_STALL_EN
      if (b == 0) check("aw_low_after_hs", bus.awready, 1'b0);
`endif
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;

    @(negedge clk);
`ifndef AXI4_MEM_SLAVE_STALL_EN
    check("b_valid_next", bus.bvalid, 1'b1);
`endif
    n = 0;
    while (!bus.bvalid && n < TMO) begin @(negedge clk); n++; end
    check("b_hs", bus.bvalid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
`ifndef AXI4_MEM_SLAVE_STALL_EN
    check("aw_ready_after_b", bus.awready, 1'b1);
`endif
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [29:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int stall_at,
                          input int stall_len);
    logic       err;
    logic [9:0] idx;
    int         n, beats, cyc, st;
    err = (size != 3'b100) || (burst != 2'b01);
    for (int b = 0; b <= int'(len); b++) begin
      idx = addr[13:4] + 10'(b);
      rq.push_back('{id: id, err: err, last: (b == int'(len)), data: mdl[idx]});
    end
    $display("read  addr=%0h len=%0d size=%0d burst=%0d id=%0d stall_at=%0d",
             addr, len, size, burst, id, stall_at);

    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < TMO);
    check("ar_hs", bus.arready, 1'b1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;

    beats = 0; cyc = 0; st = 0;
    while (beats <= int'(len) && cyc < TMO) begin
      @(negedge clk);
      cyc++;
`ifndef AXI4_MEM_SLAVE_STALL_EN
      if (cyc == 1) check("r_valid_next", bus.rvalid, 1'b1);
`endif
      if (bus.rvalid && bus.rready) beats++;
      @(posedge clk); #1;
      if (beats == stall_at && st < stall_len) begin
        bus.rready = 1'b0;
        st++;
      end else bus.rready = 1'b1;
    end
    check("r_beats", 128'(beats), 128'(int'(len) + 1));
    bus.rready = 1'b0;
    @(negedge clk);
`ifndef AXI4_MEM_SLAVE_STALL_EN
    check("ar_ready_after_r", bus.arready, 1'b1);
`endif
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rlast", bus.rlast, 1'b0);
    check("rst_rdata", bus.rdata, '0);
    check("rst_init_done", init_done, 1'b0);
    $display("reset checked");

    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (init_done) break;
      check("pre_init_awready", bus.awready, 1'b0);
      check("pre_init_arready", bus.arready, 1'b0);
      n++;
    end
    check("init_latency", 128'(n), 128'd64);
    $display("init_done after %0d cycles", n);
    @(posedge clk); #1;

    // round trip, 32 beats of data = beat index
    axi_write(30'h100, 8'd31, 3'b100, 2'b01, 4'd3, 32, 31, 128'd0, 1'b1, 16'hFFFF);
    axi_read (30'h100, 8'd31, 3'b100, 2'b01, 4'd3, -1, 0);

    // partial strobes on word 0
    axi_write(30'h0, 8'd0, 3'b100, 2'b01, 4'd1, 1, 0, '1, 1'b0, 16'hFFFF);
    axi_write(30'h0, 8'd0, 3'b100, 2'b01, 4'd2, 1, 0, '0, 1'b0, 16'h00F0);
    axi_read (30'h0, 8'd0, 3'b100, 2'b01, 4'd2, -1, 0);

    // wrap at the top word and alias above the memory size
    axi_write(30'h3FF0, 8'd1, 3'b100, 2'b01, 4'd4, 2, 1, 128'hA5A5_0000, 1'b1, 16'hFFFF);
    axi_read (30'h4000, 8'd0, 3'b100, 2'b01, 4'd5, -1, 0);
    axi_read (30'h3FF0, 8'd1, 3'b100, 2'b01, 4'd6, -1, 0);

    // error responses
    axi_write(30'h400, 8'd0, 3'b011, 2'b01, 4'd7, 1, 0, 128'h1234, 1'b0, 16'hFFFF);
    axi_write(30'h200, 8'd3, 3'b100, 2'b01, 4'd8, 2, 1, 128'h50, 1'b1, 16'hFFFF);
    axi_write(30'h300, 8'd1, 3'b100, 2'b01, 4'd9, 3, 2, 128'h70, 1'b1, 16'hFFFF);
    axi_read (30'h200, 8'd1, 3'b100, 2'b00, 4'd10, -1, 0);
    axi_read (30'h300, 8'd1, 3'b100, 2'b01, 4'd11, -1, 0);

    // backpressure mid-burst
    axi_read (30'h100, 8'd31, 3'b100, 2'b01, 4'd12, 5, 10);

    repeat (4) @(negedge clk);
    check("rq_empty", 128'(rq.size()), 128'd0);
    check("bq_empty", 128'(bq.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
